// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between the instruction memory
// and the decode stage. A circular buffer of {pc, ir} entries is filled
// from sequential fetches and drained by ID. A redirect from EX flushes
// everything and restarts fetch at redirect_pc.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              iad,
  output logic                     iad_req,
  input  logic [31:0]              idt,
  input  logic                     acki_n,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_ir,
  output logic [31:0]              deq_pc,
  output logic [31:0]              deq_pc4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  entry_t          head;

  // Fetch request, handshakes and the head-of-queue view seen by ID.
  // The request is suppressed while in reset so nothing is asked of memory.
  always_comb begin
    iad_req   = ~rst & ~redirect & (count_q != FULL);
    push      = iad_req & ~acki_n;
    deq_valid = (count_q != '0);
    pop       = deq_valid & deq_ready & ~redirect;
    head      = mem_q[rd_ptr_q];
    iad       = fetch_pc_q;
    count     = count_q;
    deq_ir    = deq_valid ? head.ir : NOP_IR;
    deq_pc    = deq_valid ? head.pc : 32'h0;
    deq_pc4   = deq_valid ? (head.pc + 32'd4) : 32'h0;
  end

  // Next-state: redirect flushes and wins over push/pop; otherwise push
  // and pop act independently and the count follows their difference.
  always_comb begin
    mem_d      = mem_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {fetch_pc_q, idt};
        wr_ptr_d        = wr_ptr_q + PW'(1);
        fetch_pc_d      = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset empties the queue and restarts fetch at RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue with a queue-level
// reference model and a negedge monitor.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_IR   = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iad;
  logic        iad_req;
  logic [31:0] idt;
  logic        acki_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_ir, deq_pc, deq_pc4;
  logic [$clog2(DEPTH):0] count;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  int          exp_count = 0;
  logic [31:0] model_pc = RESET_PC;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_IR(NOP_IR)) dut (
    .clk(clk), .rst(rst), .iad(iad), .iad_req(iad_req), .idt(idt),
    .acki_n(acki_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_ir(deq_ir),
    .deq_pc(deq_pc), .deq_pc4(deq_pc4), .count(count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  assign idt = memf(iad);

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  // Monitor: compares the DUT's presented head against the scoreboard and
  // retires the head entry when ID takes it.
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(exp_count));
    chk("iad", iad, model_pc);
    chk("iad_req", 32'(iad_req), 32'(!rst && !redirect && exp_count < int'(DEPTH)));
    chk("deq_valid", 32'(deq_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("deq_pc", deq_pc, sb[0].pc);
      chk("deq_ir", deq_ir, sb[0].ir);
      chk("deq_pc4", deq_pc4, sb[0].pc + 32'd4);
      if (!rst && !redirect && deq_ready) void'(sb.pop_front());
    end else begin
      chk("deq_ir_empty", deq_ir, NOP_IR);
      chk("deq_pc_empty", deq_pc, 32'h0);
      chk("deq_pc4_empty", deq_pc4, 32'h0);
    end
  end

  // One clock: advance the reference model using the inputs in force at
  // the edge, then let the stimulus change inputs 1 ns later.
  task automatic tick();
    bit push, pop;
    @(posedge clk);
    if (!rst) begin
      if (redirect) begin
        exp_count = 0;
        model_pc  = redirect_pc;
        sb.delete();
      end else begin
        push = (exp_count < int'(DEPTH)) && !acki_n;
        pop  = (exp_count > 0) && deq_ready;
        if (push) begin
          sb.push_back('{pc: model_pc, ir: memf(model_pc)});
          model_pc = model_pc + 32'd4;
        end
        exp_count = exp_count + int'(push) - int'(pop);
      end
    end
    #1;
  endtask

  task automatic pulse_reset(input int cycles);
    rst       = 1'b1;
    exp_count = 0;
    model_pc  = RESET_PC;
    sb.delete();
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_deq_valid", 32'(deq_valid), 32'h0);
    chk("rst_iad", iad, RESET_PC);
    chk("rst_iad_req", 32'(iad_req), 32'h0);
    repeat (cycles) tick();
    rst = 1'b0;
    #1;
    chk("post_rst_iad", iad, RESET_PC);
  endtask

  logic [31:0] held_iad;

  initial begin
    // reset
    repeat (3) tick();
    rst = 1'b0;

    // fill to full with ID stalled
    acki_n    = 1'b0;
    deq_ready = 1'b0;
    repeat (6) tick();
    chk("full_count", 32'(count), 32'd4);
    chk("full_iad", iad, 32'h10);
    chk("full_iad_req", 32'(iad_req), 32'h0);

    // pop while full: no push that cycle, then push+pop together
    deq_ready = 1'b1;
    tick();
    chk("pop_full_count", 32'(count), 32'd3);
    chk("pop_full_iad", iad, 32'h10);
    tick();
    chk("pushpop_count", 32'(count), 32'd3);
    chk("pushpop_iad", iad, 32'h14);
    deq_ready = 1'b0;

    // redirect with 3 entries queued and an ack in the same cycle
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    deq_ready   = 1'b1;
    tick();
    redirect = 1'b0;
    chk("redir_count", 32'(count), 32'h0);
    chk("redir_deq_ir", deq_ir, NOP_IR);
    chk("redir_iad", iad, 32'h100);
    deq_ready = 1'b0;
    tick();
    chk("redir_first_pc", deq_pc, 32'h100);

    // streaming from 0 with ID always ready
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    deq_ready   = 1'b1;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_pc", deq_pc, 32'(i * 4));
      chk("stream_pc4", deq_pc4, 32'(i * 4 + 4));
      chk("stream_count", 32'(count), 32'd1);
    end

    // memory stalls: fetch address holds while the queue drains
    acki_n   = 1'b1;
    held_iad = model_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_iad", iad, held_iad);
    end
    chk("stall_drained", 32'(deq_valid), 32'h0);
    chk("stall_nop", deq_ir, NOP_IR);

    // random traffic with occasional redirects and one async reset
    for (int i = 0; i < 400; i++) begin
      acki_n      = ($urandom_range(0, 3) == 0);
      deq_ready   = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                 : ($urandom & 32'hFFFF_FFFC);
      if (i == 200) begin
        redirect = 1'b0;
        #2;
        pulse_reset(2);
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
